alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_regfile.sv | 39 +++
 rtl/alu_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and decode helper for alu_sequencer.
// Imported by alu_sequencer and alu_seq_regfile.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_INV  = 4'd11;
    localparam logic [3:0] OP_NEG  = 4'd12;
    localparam logic [3:0] OP_STO  = 4'd13;
    localparam logic [3:0] OP_SWP  = 4'd14;
    localparam logic [3:0] OP_LOAD = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // ALU-result ops write Y; CMP only exercises the ALU.
    function automatic logic writes_y(input logic [3:0] op);
        return (op <= OP_NEG) && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Architectural registers A, B, Y with independent write enables.
// Ports: clock, reset (sync, high), we_a/we_b/we_y, a_d/b_d/y_d, reg_a/reg_b/reg_y.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we_a,
    input  logic             we_b,
    input  logic             we_y,
    input  logic [WIDTH-1:0] a_d,
    input  logic [WIDTH-1:0] b_d,
    input  logic [WIDTH-1:0] y_d,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] reg_y
);

    logic [WIDTH-1:0] a_q, b_q, y_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            y_q <= '0;
        end else begin
            if (we_a) a_q <= a_d;
            if (we_b) b_q <= b_d;
            if (we_y) y_q <= y_d;
        end
    end

    assign reg_a = a_q;
    assign reg_b = b_q;
    assign reg_y = y_q;

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer driving an external ALU and writing back A/B/Y.
// Ports: clock, reset, start, op, din, alu_y in; alu_sel, reg_a/b/y, busy,
// done out; zero out only when ALU_SEQ_FLAGS_EN is defined.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] reg_y,
    output logic             busy,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             zero,
`endif
    output logic             done
);

    state_t           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             we_a, we_b, we_y;
    logic [WIDTH-1:0] a_d, b_d, y_d;
    logic             wb;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    sel_d   = op;
                    hold_d  = din;
                    busy_d  = 1'b1;
                end
            end
            S_ISSUE: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wb = (state_q == S_WB);

    // Write-back decode; reset inside the regfile discards an aborted write.
    always_comb begin
        we_a = 1'b0;
        we_b = 1'b0;
        we_y = 1'b0;
        a_d  = reg_a;
        b_d  = reg_b;
        y_d  = alu_y;
        if (wb) begin
            unique case (1'b1)
                writes_y(sel_q): we_y = 1'b1;
                (sel_q == OP_STO): begin
                    we_a = 1'b1;
                    a_d  = reg_y;
                end
                (sel_q == OP_SWP): begin
                    we_a = 1'b1;
                    we_b = 1'b1;
                    a_d  = reg_b;
                    b_d  = reg_a;
                end
                (sel_q == OP_LOAD): begin
                    we_a = 1'b1;
                    we_b = 1'b1;
                    a_d  = hold_q;
                    b_d  = reg_a;
                end
                default: ;
            endcase
        end
    end

    alu_seq_regfile #(
        .WIDTH(WIDTH)
    ) u_regfile (
        .clock(clock),
        .reset(reset),
        .we_a (we_a),
        .we_b (we_b),
        .we_y (we_y),
        .a_d  (a_d),
        .b_d  (b_d),
        .y_d  (y_d),
        .reg_a(reg_a),
        .reg_b(reg_b),
        .reg_y(reg_y)
    );

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (wb) zero_d = (alu_y == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) zero_q <= 1'b0;
        else       zero_q <= zero_d;
    end

    assign zero = zero_q;
`endif

    assign alu_sel = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
